// File: rtl/fault_seq_pkg.sv
// Shared types and constants for the fault recovery sequencer: state encodings,
// fault-id values matching fault_fsm and the backoff cooldown helper.
package fault_seq_pkg;

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StSoftstart = 3'd1,
    StRun       = 3'd2,
    StDerate    = 3'd3,
    StCooldown  = 3'd4,
    StLockout   = 3'd5
  } seq_state_t;

  localparam logic [2:0] FaultNone = 3'd0;
  localparam logic [2:0] FaultUv   = 3'd1;
  localparam logic [2:0] FaultOv   = 3'd2;
  localparam logic [2:0] FaultOt   = 3'd3;
  localparam logic [2:0] FaultUc   = 3'd4;

  // base << (retry - 1), clamped to the largest value a w-bit timer can hold.
  function automatic logic [31:0] backoff_len(input int unsigned base,
                                              input int unsigned retry,
                                              input int unsigned w);
    logic [63:0] len;
    logic [63:0] cap;
    cap = (64'd1 << w) - 64'd1;
    len = 64'(base);
    if (retry > 0) len = len << (retry - 1);
    if (len > cap) len = cap;
    return len[31:0];
  endfunction

endpackage

// File: rtl/fault_recovery_sequencer_if.sv
// Bundle between the sequencer, the host and fault_fsm. The master modport is
// the host/fault_fsm side; the slave modport is the sequencer.
interface fault_seq_if;
  logic       enable_req;
  logic       unlock;
  logic       warn;
  logic       fault;
  logic       shutdown;
  logic [2:0] active_fault_id;
  logic       pwr_en;
  logic       soft_start;
  logic       derate;
  logic       lockout;
  logic       clear_warning;
  logic [1:0] retry_cnt;
  logic [2:0] trip_fault_id;
  logic [2:0] seq_state;

  modport master (
    output enable_req, unlock, warn, fault, shutdown, active_fault_id,
    input  pwr_en, soft_start, derate, lockout, clear_warning, retry_cnt, trip_fault_id,
           seq_state
  );

  modport slave (
    input  enable_req, unlock, warn, fault, shutdown, active_fault_id,
    output pwr_en, soft_start, derate, lockout, clear_warning, retry_cnt, trip_fault_id,
           seq_state
  );
endinterface

// File: rtl/seq_timer.sv
// Loadable down-counter that holds at zero; shared by the soft-start and
// cooldown intervals.
module seq_timer #(
  parameter int unsigned TMR_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [TMR_W-1:0] load_val_i,
  output logic             done_o,
  output logic             last_o
);

  logic [TMR_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - TMR_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_o = (count_q == '0);
  // Count reaches zero on the coming edge.
  assign last_o = (count_q == TMR_W'(1));

endmodule

// File: rtl/fault_recovery_sequencer.sv
// Supervisory power-stage sequencer above fault_fsm with bounded auto-retry and lockout.
// Define FAULT_SEQ_EXP_BACKOFF_EN to double the cooldown length on each consumed retry.
module fault_recovery_sequencer
  import fault_seq_pkg::*;
#(
  parameter int unsigned SOFTSTART_CYCLES = 16,
  parameter int unsigned COOLDOWN_CYCLES  = 64,
  parameter int unsigned MAX_RETRIES      = 3,
  parameter int unsigned STABLE_CYCLES    = 128,
  parameter int unsigned TMR_W            = 16
) (
  input logic        clk,
  input logic        rst,
  fault_seq_if.slave bus_io
);

  localparam logic [1:0]       MaxRetry   = 2'(MAX_RETRIES);
  localparam logic [TMR_W-1:0] SoftLen    = TMR_W'(SOFTSTART_CYCLES);
  localparam logic [TMR_W-1:0] StableLast = TMR_W'(STABLE_CYCLES - 1);

  seq_state_t       state_q, state_d;
  logic [1:0]       retry_q, retry_d, retry_inc;
  logic [2:0]       trip_q, trip_d;
  logic             cw_q, cw_d;
  logic             pwr_q, ss_q, der_q, lock_q;
  logic [TMR_W-1:0] stab_q;
  logic [TMR_W-1:0] cool_len;
  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_done, tmr_last;
  logic             powered;

  assign retry_inc = retry_q + 2'd1;
  assign powered   = (state_q == StSoftstart) || (state_q == StRun) || (state_q == StDerate);

`ifdef FAULT_SEQ_EXP_BACKOFF_EN
  assign cool_len = TMR_W'(backoff_len(COOLDOWN_CYCLES, 32'(retry_inc), TMR_W));
`else
  assign cool_len = TMR_W'(COOLDOWN_CYCLES);
`endif

  seq_timer #(
    .TMR_W(TMR_W)
  ) u_timer (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done),
    .last_o     (tmr_last)
  );

  always_comb begin
    state_d  = state_q;
    retry_d  = retry_q;
    trip_d   = trip_q;
    cw_d     = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = '0;
    if (state_q != StLockout && bus_io.shutdown) begin
      state_d = StLockout;
      trip_d  = bus_io.active_fault_id;
    end else if (powered && bus_io.fault) begin
      trip_d = bus_io.active_fault_id;
      if (retry_q == MaxRetry) begin
        state_d = StLockout;
      end else begin
        state_d  = StCooldown;
        retry_d  = retry_inc;
        tmr_load = 1'b1;
        tmr_val  = cool_len;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus_io.enable_req && !bus_io.fault) begin
            state_d  = StSoftstart;
            tmr_load = 1'b1;
            tmr_val  = SoftLen;
          end
        end
        StSoftstart: begin
          if (!bus_io.enable_req)          state_d = StIdle;
          else if (tmr_last || tmr_done)   state_d = StRun;
        end
        StRun: begin
          if (!bus_io.enable_req)          state_d = StIdle;
          else if (bus_io.warn)            state_d = StDerate;
          else if (stab_q == StableLast)   retry_d = '0;
        end
        StDerate: begin
          if (!bus_io.enable_req)          state_d = StIdle;
          else if (!bus_io.warn)           state_d = StRun;
        end
        StCooldown: begin
          if (!bus_io.enable_req) begin
            state_d = StIdle;
          end else begin
            if (tmr_last) cw_d = 1'b1;
            // Restart only once the pulse has gone out and fault_fsm has cleared.
            if (tmr_done && !bus_io.fault) begin
              state_d  = StSoftstart;
              tmr_load = 1'b1;
              tmr_val  = SoftLen;
            end
          end
        end
        StLockout: begin
          if (bus_io.unlock && !bus_io.fault && !bus_io.shutdown) begin
            state_d = StIdle;
            cw_d    = 1'b1;
            retry_d = '0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      retry_q <= '0;
      trip_q  <= '0;
      cw_q    <= 1'b0;
      pwr_q   <= 1'b0;
      ss_q    <= 1'b0;
      der_q   <= 1'b0;
      lock_q  <= 1'b0;
      stab_q  <= '0;
    end else begin
      state_q <= state_d;
      retry_q <= retry_d;
      trip_q  <= trip_d;
      cw_q    <= cw_d;
      pwr_q   <= state_d inside {StSoftstart, StRun, StDerate};
      ss_q    <= (state_d == StSoftstart);
      der_q   <= (state_d == StDerate);
      lock_q  <= (state_d == StLockout);
      if (state_q == StRun && state_d == StRun) begin
        if (stab_q != StableLast) stab_q <= stab_q + TMR_W'(1);
      end else begin
        stab_q <= '0;
      end
    end
  end

  assign bus_io.pwr_en        = pwr_q;
  assign bus_io.soft_start    = ss_q;
  assign bus_io.derate        = der_q;
  assign bus_io.lockout       = lock_q;
  assign bus_io.clear_warning = cw_q;
  assign bus_io.retry_cnt     = retry_q;
  assign bus_io.trip_fault_id = trip_q;
  assign bus_io.seq_state     = state_q;

endmodule

// File: tb/tb_fault_recovery_sequencer.sv
// Scoreboard bench: stimulus queues each expected output change with its spacing
// in cycles; a negedge monitor pops and compares whenever the outputs change.
module tb_fault_recovery_sequencer;

  typedef struct packed {
    logic [2:0] st;
    logic       pwr;
    logic       ss;
    logic       der;
    logic       lk;
    logic       cw;
    logic [1:0] rc;
    logic [2:0] tid;
  } obs_t;

  typedef struct {
    obs_t        o;
    int unsigned dt;
  } exp_t;

  logic clk;
  logic rst;

  fault_seq_if bus ();

  fault_recovery_sequencer dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          obs_idx = 0;
  bit          mon_en = 1'b0;
  obs_t        last;
  int unsigned last_cyc;
  exp_t        exp_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic obs_t sample();
    obs_t s;
    s.st  = bus.seq_state;
    s.pwr = bus.pwr_en;
    s.ss  = bus.soft_start;
    s.der = bus.derate;
    s.lk  = bus.lockout;
    s.cw  = bus.clear_warning;
    s.rc  = bus.retry_cnt;
    s.tid = bus.trip_fault_id;
    return s;
  endfunction

  function automatic string fmt(input obs_t s);
    return $sformatf("st=%0d pwr=%0b ss=%0b der=%0b lk=%0b cw=%0b rc=%0d tid=%0d",
                     s.st, s.pwr, s.ss, s.der, s.lk, s.cw, s.rc, s.tid);
  endfunction

  function automatic obs_t mk(input logic [2:0] st, input logic pwr, input logic ss,
                              input logic der, input logic lk, input logic cw,
                              input logic [1:0] rc, input logic [2:0] tid);
    obs_t s;
    s.st = st; s.pwr = pwr; s.ss = ss; s.der = der;
    s.lk = lk; s.cw = cw; s.rc = rc; s.tid = tid;
    return s;
  endfunction

  function automatic int unsigned cool_len(input int unsigned r);
`ifdef FAULT_SEQ_EXP_BACKOFF_EN
    return 64 << (r - 1);
`else
    return 64;
`endif
  endfunction

  // dt of 0 means the spacing to the previous change is not checked.
  task automatic expect_obs(input obs_t o, input int unsigned dt);
    exp_t e;
    e.o  = o;
    e.dt = dt;
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_now(input string name, input obs_t want);
    obs_t got;
    got = sample();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %s, required %s", name, fmt(got), fmt(want));
    end
  endtask

  // Fault trip from RUN (entered 3 edges earlier) through cooldown to the restart.
  task automatic retry_cycle(input logic [2:0] id, input logic [1:0] rnew, input int hold,
                             input bit stop_in_ss);
    int unsigned cl;
    cl = cool_len(rnew);
    expect_obs(mk(3'd4, 0, 0, 0, 0, 0, rnew, id), 3);
    expect_obs(mk(3'd4, 0, 0, 0, 0, 1, rnew, id), cl);
    expect_obs(mk(3'd1, 1, 1, 0, 0, 0, rnew, id), 1);
    if (!stop_in_ss) expect_obs(mk(3'd2, 1, 0, 0, 0, 0, rnew, id), 16);
    bus.fault = 1'b1;
    bus.active_fault_id = id;
    step(hold);
    bus.fault = 1'b0;
    if (stop_in_ss) step(int'(cl) + 4 - hold);
    else            step(int'(cl) + 20 - hold);
  endtask

  always @(negedge clk) begin
    obs_t        cur;
    exp_t        e;
    int unsigned dt;
    if (mon_en) begin
      cur = sample();
      if (cur !== last) begin
        dt = cyc - last_cyc;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change_%0d: got %s dt=%0d, required no change",
                   obs_idx, fmt(cur), dt);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e.o || (e.dt != 0 && dt != e.dt)) begin
            errors++;
            $display("FAIL obs_%0d: got %s dt=%0d, required %s dt=%0d",
                     obs_idx, fmt(cur), dt, fmt(e.o), e.dt);
          end
        end
        obs_idx++;
        last     = cur;
        last_cyc = cyc;
      end
    end
  end

  initial begin
    obs_t zero;
    zero = '0;
    rst = 1'b0;
    bus.enable_req = 1'b0;
    bus.unlock = 1'b0;
    bus.warn = 1'b0;
    bus.fault = 1'b0;
    bus.shutdown = 1'b0;
    bus.active_fault_id = 3'd0;
    #1 rst = 1'b1;
    #1 check_now("reset_state", zero);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    last     = sample();
    last_cyc = cyc;
    mon_en   = 1'b1;

    // Power-up: soft-start on the next edge, RUN 16 cycles later.
    expect_obs(mk(3'd1, 1, 1, 0, 0, 0, 2'd0, 3'd0), 0);
    expect_obs(mk(3'd2, 1, 0, 0, 0, 0, 2'd0, 3'd0), 16);
    bus.enable_req = 1'b1;
    step(20);

    // Derate for 5 warn cycles, power kept on.
    expect_obs(mk(3'd3, 1, 0, 1, 0, 0, 2'd0, 3'd0), 4);
    expect_obs(mk(3'd2, 1, 0, 0, 0, 0, 2'd0, 3'd0), 5);
    bus.warn = 1'b1;
    step(5);
    bus.warn = 1'b0;
    step(3);

    // Single retry on OV with fault held 10 cycles, then two more retries.
    retry_cycle(3'd2, 2'd1, 10, 1'b0);
    retry_cycle(3'd3, 2'd2, 1, 1'b0);
    retry_cycle(3'd1, 2'd3, 1, 1'b0);

    // Fourth fault exhausts retries; host inputs ignored in lockout.
    expect_obs(mk(3'd5, 0, 0, 0, 1, 0, 2'd3, 3'd4), 3);
    bus.fault = 1'b1;
    bus.active_fault_id = 3'd4;
    step(1);
    bus.fault = 1'b0;
    bus.enable_req = 1'b0;
    step(3);
    bus.enable_req = 1'b1;
    step(3);
    bus.warn = 1'b1;
    step(2);
    bus.warn = 1'b0;
    bus.enable_req = 1'b0;
    step(2);
    expect_obs(mk(3'd0, 0, 0, 0, 0, 1, 2'd0, 3'd4), 0);
    expect_obs(mk(3'd0, 0, 0, 0, 0, 0, 2'd0, 3'd4), 1);
    bus.unlock = 1'b1;
    step(1);
    bus.unlock = 1'b0;
    step(3);

    // Shutdown with fault during SOFTSTART goes straight to lockout, retry kept.
    expect_obs(mk(3'd1, 1, 1, 0, 0, 0, 2'd0, 3'd4), 0);
    expect_obs(mk(3'd2, 1, 0, 0, 0, 0, 2'd0, 3'd4), 16);
    bus.enable_req = 1'b1;
    step(19);
    retry_cycle(3'd2, 2'd1, 1, 1'b1);
    expect_obs(mk(3'd5, 0, 0, 0, 1, 0, 2'd1, 3'd3), 3);
    bus.shutdown = 1'b1;
    bus.fault = 1'b1;
    bus.active_fault_id = 3'd3;
    step(1);
    bus.fault = 1'b0;
    step(1);
    bus.unlock = 1'b1;
    step(1);
    bus.unlock = 1'b0;
    bus.shutdown = 1'b0;
    bus.fault = 1'b1;
    step(1);
    bus.unlock = 1'b1;
    step(1);
    bus.unlock = 1'b0;
    bus.fault = 1'b0;
    step(3);
    bus.enable_req = 1'b0;
    expect_obs(mk(3'd0, 0, 0, 0, 0, 1, 2'd0, 3'd3), 0);
    expect_obs(mk(3'd0, 0, 0, 0, 0, 0, 2'd0, 3'd3), 1);
    bus.unlock = 1'b1;
    step(1);
    bus.unlock = 1'b0;
    step(2);

    // Asynchronous reset in the middle of a cooldown.
    expect_obs(mk(3'd1, 1, 1, 0, 0, 0, 2'd0, 3'd3), 0);
    expect_obs(mk(3'd2, 1, 0, 0, 0, 0, 2'd0, 3'd3), 16);
    bus.enable_req = 1'b1;
    step(19);
    expect_obs(mk(3'd4, 0, 0, 0, 0, 0, 2'd1, 3'd1), 3);
    bus.fault = 1'b1;
    bus.active_fault_id = 3'd1;
    step(1);
    bus.fault = 1'b0;
    step(10);
    expect_obs(zero, 0);
    #2 rst = 1'b1;
    #1 check_now("async_reset_cooldown", zero);
    bus.enable_req = 1'b0;
    step(2);
    rst = 1'b0;
    step(3);
    check_now("post_reset_idle", zero);
    step(2);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expected: got %0d pending, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
